// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: MEM/WB writeback select, jal link, 32x32 regfile with write-first ID reads, forwarding and display taps
//   in : clk, reset (sync, active-high), RegWrite_wb, MemToReg_wb, MemData_wb, ALUResult_wb, WriteReg_wb,
//        pcPlus4_wb, jump_wb, extend_jump_wb, ReadReg1, ReadReg2
//   out: ReadData1/2 (bypassed), WB_WriteData/WriteReg/RegWrite (forwarding), JumpTarget, sad_result, v1_out, wb_count
module wb_regfile_stage #(
  parameter int NREGS = 32,
  parameter int RA_INDEX = 31,
  parameter int SAD_RESULT_REG = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_wb,
  input  logic [2:0]  MemToReg_wb,
  input  logic [31:0] MemData_wb,
  input  logic [31:0] ALUResult_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] pcPlus4_wb,
  input  logic [2:0]  jump_wb,
  input  logic [27:0] extend_jump_wb,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] WB_WriteData,
  output logic [4:0]  WB_WriteReg,
  output logic        WB_RegWrite,
  output logic [31:0] JumpTarget,
  output logic [31:0] sad_result,
  output logic [31:0] v1_out,
  output logic [15:0] wb_count
);
  // power-up contents match the reset state
  logic [31:0] regs [NREGS] = '{default: '0};
  logic [15:0] cnt = '0;
  logic        jal;
  assign jal = jump_wb == 3'd2;
  always_comb begin
    WB_WriteData = jal ? pcPlus4_wb :
                   MemToReg_wb == 3'd1 ? MemData_wb :
                   MemToReg_wb == 3'd2 ? pcPlus4_wb : ALUResult_wb;
    WB_WriteReg  = jal ? 5'(RA_INDEX) : WriteReg_wb;
    WB_RegWrite  = (RegWrite_wb | jal) & (WB_WriteReg != 5'd0) & ~reset;
    ReadData1    = (reset || ReadReg1 == 5'd0) ? 32'd0 :
                   (WB_RegWrite && ReadReg1 == WB_WriteReg) ? WB_WriteData : regs[ReadReg1];
    ReadData2    = (reset || ReadReg2 == 5'd0) ? 32'd0 :
                   (WB_RegWrite && ReadReg2 == WB_WriteReg) ? WB_WriteData : regs[ReadReg2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      cnt <= '0;
    end else if (WB_RegWrite) begin
      regs[WB_WriteReg] <= WB_WriteData;
      cnt <= cnt + 16'd1;
    end
  end
  assign JumpTarget = {pcPlus4_wb[31:28], extend_jump_wb};
  assign sad_result = regs[SAD_RESULT_REG];
  assign v1_out     = regs[3];
  assign wb_count   = cnt;
endmodule

// File: tb/tb_wb_regfile_stage.sv
// tb_wb_regfile_stage: table-driven directed check of wb_regfile_stage plus reset and counter-wrap sequences
module tb_wb_regfile_stage;
  logic        clk = 0;
  logic        reset;
  logic        RegWrite_wb;
  logic [2:0]  MemToReg_wb;
  logic [31:0] MemData_wb;
  logic [31:0] ALUResult_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] pcPlus4_wb;
  logic [2:0]  jump_wb;
  logic [27:0] extend_jump_wb;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WB_WriteData;
  logic [4:0]  WB_WriteReg;
  logic        WB_RegWrite;
  logic [31:0] JumpTarget;
  logic [31:0] sad_result;
  logic [31:0] v1_out;
  logic [15:0] wb_count;
  int total = 0;
  int bad = 0;

  wb_regfile_stage dut (
    .clk(clk), .reset(reset), .RegWrite_wb(RegWrite_wb), .MemToReg_wb(MemToReg_wb),
    .MemData_wb(MemData_wb), .ALUResult_wb(ALUResult_wb), .WriteReg_wb(WriteReg_wb),
    .pcPlus4_wb(pcPlus4_wb), .jump_wb(jump_wb), .extend_jump_wb(extend_jump_wb),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WB_WriteData(WB_WriteData), .WB_WriteReg(WB_WriteReg), .WB_RegWrite(WB_RegWrite),
    .JumpTarget(JumpTarget), .sad_result(sad_result), .v1_out(v1_out), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [2:0]  mtr;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [31:0] pc4;
    logic [2:0]  jmp;
    logic [27:0] ej;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_wd;
    logic [4:0]  e_wr;
    logic        e_we;
    logic [31:0] e_jt;
    logic [15:0] e_cnt;
    logic [31:0] e_sad;
    logic [31:0] e_v1;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [2:0] mtr, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] wreg, input logic [31:0] pc4, input logic [2:0] jmp,
                       input logic [27:0] ej, input logic [4:0] rr1, input logic [4:0] rr2);
    RegWrite_wb = rw; MemToReg_wb = mtr; MemData_wb = mem; ALUResult_wb = alu; WriteReg_wb = wreg;
    pcPlus4_wb = pc4; jump_wb = jmp; extend_jump_wb = ej; ReadReg1 = rr1; ReadReg2 = rr2;
  endtask

  initial begin
    vt[0]  = '{1'b1, 3'd0, 32'h0, 32'hAB, 5'd5, 32'h0, 3'd0, 28'h0, 5'd5, 5'd0,
               32'hAB, 32'h0, 32'hAB, 5'd5, 1'b1, 32'h0, 16'd1, 32'h0, 32'h0};
    vt[1]  = '{1'b0, 3'd0, 32'h0, 32'h1234, 5'd0, 32'h0, 3'd0, 28'h0, 5'd5, 5'd5,
               32'hAB, 32'hAB, 32'h1234, 5'd0, 1'b0, 32'h0, 16'd1, 32'h0, 32'h0};
    vt[2]  = '{1'b1, 3'd1, 32'hDEADBEEF, 32'h11111111, 5'd2, 32'h0, 3'd0, 28'h0, 5'd2, 5'd5,
               32'hDEADBEEF, 32'hAB, 32'hDEADBEEF, 5'd2, 1'b1, 32'h0, 16'd2, 32'hDEADBEEF, 32'h0};
    vt[3]  = '{1'b0, 3'd1, 32'h999, 32'h0, 5'd7, 32'h40, 3'd2, 28'h0000100, 5'd31, 5'd7,
               32'h40, 32'h0, 32'h40, 5'd31, 1'b1, 32'h00000100, 16'd3, 32'hDEADBEEF, 32'h0};
    vt[4]  = '{1'b0, 3'd2, 32'h0, 32'h0, 5'd3, 32'hA0000000, 3'd0, 28'hFFFFFFC, 5'd31, 5'd7,
               32'h40, 32'h0, 32'hA0000000, 5'd3, 1'b0, 32'hAFFFFFFC, 16'd3, 32'hDEADBEEF, 32'h0};
    vt[5]  = '{1'b1, 3'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 32'h0, 3'd0, 28'h0, 5'd0, 5'd0,
               32'h0, 32'h0, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h0, 16'd3, 32'hDEADBEEF, 32'h0};
    vt[6]  = '{1'b1, 3'd2, 32'h0, 32'h0, 5'd3, 32'h1000, 3'd0, 28'h0, 5'd3, 5'd2,
               32'h1000, 32'hDEADBEEF, 32'h1000, 5'd3, 1'b1, 32'h0, 16'd4, 32'hDEADBEEF, 32'h1000};
    vt[7]  = '{1'b1, 3'd5, 32'h88, 32'h77, 5'd3, 32'h99, 3'd0, 28'h0, 5'd3, 5'd31,
               32'h77, 32'h40, 32'h77, 5'd3, 1'b1, 32'h0, 16'd5, 32'hDEADBEEF, 32'h77};
    vt[8]  = '{1'b0, 3'd0, 32'h0, 32'h5, 5'd6, 32'h0, 3'd3, 28'h0, 5'd6, 5'd3,
               32'h0, 32'h77, 32'h5, 5'd6, 1'b0, 32'h0, 16'd5, 32'hDEADBEEF, 32'h77};
    vt[9]  = '{1'b1, 3'd0, 32'h0, 32'h5, 5'd6, 32'h0, 3'd1, 28'h0, 5'd6, 5'd3,
               32'h5, 32'h77, 32'h5, 5'd6, 1'b1, 32'h0, 16'd6, 32'hDEADBEEF, 32'h77};
    vt[10] = '{1'b1, 3'd3, 32'h0, 32'hBAD, 5'd3, 32'h2000, 3'd2, 28'h0, 5'd3, 5'd31,
               32'h77, 32'h2000, 32'h2000, 5'd31, 1'b1, 32'h0, 16'd7, 32'hDEADBEEF, 32'h77};

    reset = 1;
    drive(1'b1, 3'd0, 32'h0, 32'hAB, 5'd5, 32'h0, 3'd0, 28'h0, 5'd5, 5'd5);
    #1;
    chk("rst_we", {31'd0, WB_RegWrite}, 32'd0);
    chk("rst_rd1", ReadData1, 32'd0);
    chk("rst_rd2", ReadData2, 32'd0);
    @(posedge clk); #1;
    chk("rst_cnt", {16'd0, wb_count}, 32'd0);
    chk("rst_sad", sad_result, 32'd0);
    chk("rst_v1", v1_out, 32'd0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].rw, vt[i].mtr, vt[i].mem, vt[i].alu, vt[i].wreg, vt[i].pc4, vt[i].jmp, vt[i].ej, vt[i].rr1, vt[i].rr2);
      #1;
      chk($sformatf("v%0d_rd1", i), ReadData1, vt[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), ReadData2, vt[i].e_rd2);
      chk($sformatf("v%0d_wd", i), WB_WriteData, vt[i].e_wd);
      chk($sformatf("v%0d_wr", i), {27'd0, WB_WriteReg}, {27'd0, vt[i].e_wr});
      chk($sformatf("v%0d_we", i), {31'd0, WB_RegWrite}, {31'd0, vt[i].e_we});
      chk($sformatf("v%0d_jt", i), JumpTarget, vt[i].e_jt);
      @(posedge clk); #1;
      chk($sformatf("v%0d_cnt", i), {16'd0, wb_count}, {16'd0, vt[i].e_cnt});
      chk($sformatf("v%0d_sad", i), sad_result, vt[i].e_sad);
      chk($sformatf("v%0d_v1", i), v1_out, vt[i].e_v1);
      @(negedge clk);
    end

    // post-table readback: reg7 untouched by jal, reg5 retained
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 3'd0, 28'h0, 5'd7, 5'd5);
    #1;
    chk("rb_r7", ReadData1, 32'h0);
    chk("rb_r5", ReadData2, 32'hAB);

    // write colliding with reset is discarded
    @(negedge clk);
    reset = 1;
    drive(1'b1, 3'd0, 32'h0, 32'h55, 5'd3, 32'h0, 3'd0, 28'h0, 5'd3, 5'd2);
    #1;
    chk("col_we", {31'd0, WB_RegWrite}, 32'd0);
    chk("col_rd1", ReadData1, 32'd0);
    @(posedge clk); #1;
    chk("col_v1", v1_out, 32'd0);
    chk("col_sad", sad_result, 32'd0);
    chk("col_cnt", {16'd0, wb_count}, 32'd0);
    @(negedge clk);
    reset = 0;
    ALUResult_wb = 32'h66;
    @(posedge clk); #1;
    chk("post_v1", v1_out, 32'h66);
    chk("post_cnt", {16'd0, wb_count}, 32'd1);

    // counter wrap: clear, then 65536 commits to reg 4
    @(negedge clk);
    reset = 1;
    RegWrite_wb = 0;
    @(negedge clk);
    reset = 0;
    drive(1'b1, 3'd0, 32'h0, 32'h0, 5'd4, 32'h0, 3'd0, 28'h0, 5'd4, 5'd0);
    for (int i = 0; i < 65536; i++) begin
      ALUResult_wb = i;
      @(negedge clk);
      if (i == 65534) chk("wrap_ffff", {16'd0, wb_count}, 32'h0000FFFF);
    end
    RegWrite_wb = 0;
    #1;
    chk("wrap_cnt", {16'd0, wb_count}, 32'd0);
    chk("wrap_r4", ReadData1, 32'd65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
Consumer end of the MEM/WB pipeline register. Each cycle it takes the registered MEM/WB outputs and selects the writeback value. It resolves the effective destination, including jal linking to $ra, and commits the result into a 32x32 register file. It serves the two ID-stage read ports with write-first bypass, drives WB forwarding data toward EX, and drives a jump-target bus plus SAD result taps ($v0, $v1) for the board display.

Parameters:
NREGS, 32, number of architectural registers (index width fixed at 5)
RA_INDEX, 31, link register written by jal
SAD_RESULT_REG, 2, register index exported on sad_result ($v0)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high
RegWrite_wb  input  1  write enable from MEM/WB
MemToReg_wb  input  3  writeback source select
MemData_wb  input  32  load data
ALUResult_wb  input  32  ALU result
WriteReg_wb  input  5  destination index before jal override
pcPlus4_wb  input  32  PC+4 of the WB instruction
jump_wb  input  3  jump class: 0 none, 1 j, 2 jal, 3 jr
extend_jump_wb  input  28  instr_index shifted left by 2
ReadReg1  input  5  ID read address A
ReadReg2  input  5  ID read address B
ReadData1  output  32  ID read data A
ReadData2  output  32  ID read data B
WB_WriteData  output  32  selected writeback value (forwarding)
WB_WriteReg  output  5  effective destination (forwarding)
WB_RegWrite  output  1  effective write enable (forwarding)
JumpTarget  output  32  {pcPlus4_wb[31:28], extend_jump_wb}
sad_result  output  32  content of SAD_RESULT_REG
v1_out  output  32  content of register 3
wb_count  output  16  count of committed non-zero-register writes

Behaviour:
- Writeback select, combinational:
  - MemToReg_wb 0 -> ALUResult_wb; 1 -> MemData_wb; 2 -> pcPlus4_wb.
  - 3..7 -> ALUResult_wb.
  - jump_wb==2 (jal) overrides and selects pcPlus4_wb regardless of MemToReg_wb.
- Effective destination: WB_WriteReg = RA_INDEX when jump_wb==2, else WriteReg_wb.
- Effective enable: WB_RegWrite = RegWrite_wb OR (jump_wb==2), forced 0 when WB_WriteReg==0 or reset==1.
- jump_wb 1 and 3 never write by themselves; they write only if RegWrite_wb==1.
- Commit: on posedge clk, if WB_RegWrite, regs[WB_WriteReg] <= WB_WriteData. One write per cycle.
- Register 0: never written, always reads 0.
- Reads, combinational, write-first:
  - If WB_RegWrite and ReadRegN==WB_WriteReg, ReadDataN = WB_WriteData (same-cycle bypass, no one-cycle bubble for ID).
  - Otherwise ReadDataN = regs[ReadRegN].
  - Reading index 0 yields 0 even if WB_WriteReg==0.
- JumpTarget: purely combinational, valid for all jump_wb values; consumers qualify it with jump_wb.
- sad_result, v1_out: registered contents only, no bypass; they update the cycle after the commit.
- wb_count: increments by 1 on each commit edge. Wraps 0xFFFF -> 0x0000.
- Reset, synchronous:
  - On posedge clk with reset==1, all regs <= 0 and wb_count <= 0. Any pending write that edge is discarded; reset wins.
  - While reset==1: ReadData1, ReadData2, WB_RegWrite forced 0.
  - sad_result, v1_out, wb_count read 0 from the first edge after reset is asserted.
- Initial power-up state equals the reset state, so simulation without reset starts from zeros.
- Reset mid-stream: an instruction in WB during the reset edge is lost. The first post-reset write lands on the first edge with reset==0.
- Latency:
  - Write-to-architectural-state: 1 edge.
  - Write-to-ID-visible: 0 cycles, via bypass.
  - Forwarding outputs: 0 cycles, combinational from inputs.

Test Plan:
- Reset, then RegWrite_wb=1, MemToReg=0, ALUResult=0x0000_00AB, WriteReg=5, ReadReg1=5 in the same cycle -> ReadData1=0xAB before the edge (bypass); after the edge ReadReg1=5 still reads 0xAB; wb_count=1.
- Load path: MemToReg=1, MemData=0xDEAD_BEEF, WriteReg=2 -> after the edge, sad_result=0xDEADBEEF; ALUResult ignored.
- jal: jump_wb=2, RegWrite_wb=0, WriteReg=7, pcPlus4=0x0000_0040, extend_jump=0x000_0100 -> reg31=0x40, reg7 unchanged, JumpTarget=0x0000_0100, WB_RegWrite=1.
- $zero: RegWrite=1, WriteReg=0, ALUResult=0xFFFF_FFFF -> WB_RegWrite=0, ReadData2 on index 0 reads 0, wb_count unchanged.
- Reset collision: write 0x55 to reg 3 on the same edge reset==1 -> v1_out=0 after the edge; the next write of 0x66 with reset==0 gives v1_out=0x66.
- Counter wrap: 65536 committed writes to reg 4 -> wb_count returns to 0x0000; the last written value is retained.
